seq_magnitude_comparator: RTL
=============================

// Module: seq_magnitude_comparator
// PURPOSE
//  Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
//  Compares one SLICE-bit slice per clock, MSB slice first, and stops early at the first unequal slice.
//  Supports unsigned and signed (two's complement) modes and keeps the cascade-in tie-break (GreaterIn/LessIn priority).
//  Sits between operand producers and control logic through valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH       32  operand width in bits; must be an integer multiple of SLICE
//  SLICE        4  bits compared per cycle
//  NUM_SLICES  WIDTH/SLICE  derived localparam; not overridable
//  CNT_W       $clog2(NUM_SLICES+1)  derived localparam; width of cycles_used
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          synchronous, active-high
//  in_valid     in   1          operands and mode are valid
//  in_ready     out  1          block can accept operands (IDLE only)
//  signed_mode  in   1          1 = two's complement compare, 0 = unsigned
//  A, B         in   WIDTH      operands
//  EqualIn      in   1          cascade tie-break input, lowest priority
//  GreaterIn    in   1          cascade tie-break input, highest priority
//  LessIn       in   1          cascade tie-break input, middle priority
//  out_valid    out  1          result valid; held until accepted
//  out_ready    in   1          consumer accepts result
//  EqualOut     out  1          one-hot result: A == B
//  GreaterOut   out  1          one-hot result: A > B
//  LessOut      out  1          one-hot result: A < B
//  cycles_used  out  CNT_W      number of slices examined, range 1..NUM_SLICES
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0 in the reset cycle and 1 afterwards.
//    out_valid, EqualOut, GreaterOut, LessOut and cycles_used are 0.
//  - States:
//    - IDLE: in_ready=1. On in_valid, capture A, B, signed_mode and the cascade inputs, set idx=NUM_SLICES-1, go to CMP.
//    - CMP: compare slice idx of the captured operands.
//      - Slices differ: set the result, go to DONE.
//      - Slices equal and idx>0: decrement idx, stay in CMP.
//      - Slices equal and idx==0: tie-break on the captured cascade inputs: GreaterIn -> greater, else LessIn -> less, else equal. Go to DONE.
//    - DONE: out_valid=1 and outputs stable. On out_ready, go to IDLE and clear out_valid.
//  - Signed mode: invert the MSB of both top slices before comparing (offset binary). All lower slices compare unsigned.
//  - Latency: out_valid rises k cycles after the accept edge, where k = slices examined (1..NUM_SLICES). cycles_used = k.
//  - Throughput: in_ready is low outside IDLE, so there is at least 1 idle cycle between results. No back-to-back accept in DONE.
//  - Result outputs are exactly one-hot whenever out_valid=1 and are registered, with no combinational paths from inputs.
//  - Changes to A, B or the cascade inputs after accept have no effect until the next accept.
//  - out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored (not queued).
//  - Reset mid-CMP or mid-DONE: abort immediately and return to the reset values. The pending result is lost.
//  - Elaboration check: error if WIDTH % SLICE != 0 or SLICE < 1.
// STRUCTURE
//  - Package cmp_pkg:
//    - state typedef {IDLE, CMP, DONE}
//    - result typedef {RES_EQ, RES_GT, RES_LT}
//    - function res_to_onehot
//  - Sub-module comparator_slice #(SLICE): combinational; inputs a, b; outputs gt, lt. One instance, fed by a slice mux on idx.
//  - Top level: FSM, idx down-counter, operand/cascade capture registers, result register.
// TESTING (WIDTH=16, SLICE=4)
//  1. Unsigned A=16'h8000, B=16'h7FFF -> GreaterOut=1, cycles_used=1, out_valid 1 cycle after accept.
//  2. Signed, same operands -> LessOut=1, cycles_used=1.
//     Signed A=16'hFFFF, B=16'hFFFE -> GreaterOut=1, cycles_used=4.
//  3. A=16'h1234, B=16'h1235 -> LessOut=1, cycles_used=4.
//     A=16'h1234, B=16'h1334 -> LessOut=1, cycles_used=2.
//  4. A=B=16'hABCD:
//     - GreaterIn=1, LessIn=1 -> GreaterOut=1.
//     - GreaterIn=0, LessIn=1 -> LessOut=1.
//     - all cascade inputs 0 -> EqualOut=1. cycles_used=4 in every case.
//  5. Backpressure: out_ready low for 3 cycles -> outputs and out_valid held stable and in_ready=0; ready high -> IDLE next cycle.
//     Change A during CMP -> result unchanged.
//  6. Assert reset during CMP at idx=2 -> all outputs 0 next cycle.
//     New compare A=16'h0001, B=16'h0000 -> GreaterOut=1, cycles_used=4.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// FSM states, result encoding and one-hot result helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ,
        RES_GT,
        RES_LT
    } res_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } onehot_t;

    function automatic onehot_t res_to_onehot(input res_t r);
        onehot_t oh;
        oh = '0;
        unique case (r)
            RES_EQ: oh.eq = 1'b1;
            RES_GT: oh.gt = 1'b1;
            RES_LT: oh.lt = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// Combinational unsigned compare of one operand slice.
// Signed handling is done upstream by flipping the top slice MSB.
module comparator_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator, one slice per clock, MSB first.
// Early exit on the first unequal slice; cascade inputs break ties.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int SLICE      = 4,
    localparam int NUM_SLICES = WIDTH / SLICE,
    localparam int CNT_W      = $clog2(NUM_SLICES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             EqualIn,
    input  logic             GreaterIn,
    input  logic             LessIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             EqualOut,
    output logic             GreaterOut,
    output logic             LessOut,
    output logic [CNT_W-1:0] cycles_used
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_SLICES - 1);

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : gBadCfg
        $error("WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           stateQ;
    state_t           stateNext;
    logic             inReadyQ;
    logic [IDX_W-1:0] idxQ;
    logic [CNT_W-1:0] cntQ;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic             signedQ;
    logic             gtInQ;
    logic             ltInQ;
    logic             outValidQ;
    onehot_t          outQ;
    logic [CNT_W-1:0] cyclesQ;

    logic             accept;
    logic             finish;
    res_t             resNext;
    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             sliceGt;
    logic             sliceLt;

    // Equality is the fall-through tie-break, so this input carries no information.
    logic unusedEqIn;
    assign unusedEqIn = EqualIn;

    // Select slice idx; in signed mode the top slice becomes offset binary.
    always_comb begin
        aShift = aQ >> (idxQ * SLICE);
        bShift = bQ >> (idxQ * SLICE);
        sliceA = aShift[SLICE-1:0];
        sliceB = bShift[SLICE-1:0];
        if (signedQ && (idxQ == TOP_IDX)) begin
            sliceA[SLICE-1] = ~sliceA[SLICE-1];
            sliceB[SLICE-1] = ~sliceB[SLICE-1];
        end
    end

    comparator_slice #(
        .SLICE(SLICE)
    ) uSlice (
        .a (sliceA),
        .b (sliceB),
        .gt(sliceGt),
        .lt(sliceLt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next-state decode and per-cycle compare outcome.
    always_comb begin
        stateNext = stateQ;
        accept    = 1'b0;
        finish    = 1'b0;
        resNext   = RES_EQ;
        unique case (stateQ)
            IDLE: begin
                if (in_valid && inReadyQ) begin
                    accept    = 1'b1;
                    stateNext = CMP;
                end
            end
            CMP: begin
                if (sliceGt) begin
                    finish  = 1'b1;
                    resNext = RES_GT;
                end else if (sliceLt) begin
                    finish  = 1'b1;
                    resNext = RES_LT;
                end else if (idxQ == '0) begin
                    finish = 1'b1;
                    if (gtInQ) begin
                        resNext = RES_GT;
                    end else if (ltInQ) begin
                        resNext = RES_LT;
                    end else begin
                        resNext = RES_EQ;
                    end
                end
                if (finish) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture, slice walk and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            inReadyQ  <= 1'b0;
            idxQ      <= '0;
            cntQ      <= '0;
            aQ        <= '0;
            bQ        <= '0;
            signedQ   <= 1'b0;
            gtInQ     <= 1'b0;
            ltInQ     <= 1'b0;
            outValidQ <= 1'b0;
            outQ      <= '0;
            cyclesQ   <= '0;
        end else begin
            inReadyQ <= (stateNext == IDLE);
            if (accept) begin
                aQ      <= A;
                bQ      <= B;
                signedQ <= signed_mode;
                gtInQ   <= GreaterIn;
                ltInQ   <= LessIn;
                idxQ    <= TOP_IDX;
                cntQ    <= CNT_W'(1);
            end
            if (stateQ == CMP) begin
                if (finish) begin
                    outValidQ <= 1'b1;
                    outQ      <= res_to_onehot(resNext);
                    cyclesQ   <= cntQ;
                end else begin
                    idxQ <= idxQ - 1'b1;
                    cntQ <= cntQ + 1'b1;
                end
            end
            if ((stateQ == DONE) && out_ready) begin
                outValidQ <= 1'b0;
                outQ      <= '0;
                cyclesQ   <= '0;
            end
        end
    end

    assign in_ready    = inReadyQ;
    assign out_valid   = outValidQ;
    assign EqualOut    = outQ.eq;
    assign GreaterOut  = outQ.gt;
    assign LessOut     = outQ.lt;
    assign cycles_used = cyclesQ;

endmodule
